// File: rtl/median_window_ctrl.sv
`timescale 1ns/1ps
// Purpose : sequences the 2x-downscaled 3x3 median datapath from VGA hcount/vcount:
//           line-buffer writes, row rotation, window issue, border mask, aligned result valid/coords.
// Latency : rd_col/win_mask/rotate 1 clk after the timing inputs; wr_en/wr_addr 2 clk;
//           out_valid/out_x/out_y LATENCY clk after the window issue.
// Backpressure: none; free-running from the timing counters, no stall input.
//
// Ports: clk, rst (async active-low); hcount/vcount (11b VGA counters); enable (sampled at SOF);
//        wr_en/wr_addr (line_buffer_2 write); rotate (buffer shift pulse); rd_col/win_mask (window);
//        out_valid/out_x/out_y (median result); busy/state/frame_done (status).
// Build option: define MEDIAN_CTRL_STATS_EN to add saturating frame_cnt (16b) and abort_cnt (8b).
module median_window_ctrl #(
    parameter int WIDTH   = 400,
    parameter int HEIGHT  = 300,
    parameter int LATENCY = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] hcount,
    input  logic [10:0] vcount,
    input  logic        enable,
    output logic        wr_en,
    output logic [8:0]  wr_addr,
    output logic        rotate,
    output logic [8:0]  rd_col,
    output logic [8:0]  win_mask,
    output logic        out_valid,
    output logic [8:0]  out_x,
    output logic [8:0]  out_y,
    output logic        busy,
    output logic [1:0]  state,
    output logic        frame_done
`ifdef MEDIAN_CTRL_STATS_EN
    ,
    output logic [15:0] frame_cnt,
    output logic [7:0]  abort_cnt
`endif
);

    typedef enum logic [1:0] {IDLE = 2'd0, PRIME = 2'd1, RUN = 2'd2, FLUSH = 2'd3} state_t;

    localparam logic [9:0] W_C = 10'(WIDTH);
    localparam logic [9:0] H_C = 10'(HEIGHT);

    state_t     cur, nxt;
    logic [9:0] col, row;
    logic       sof, row_start, wr_slot, iss_slot;
    logic       abort, done, wr_now, rot_now, iss_now;
    logic [8:0] mask_now;

    assign col       = hcount[10:1];
    assign row       = vcount[10:1];
    assign sof       = (hcount == 11'd0) && (vcount == 11'd0);
    assign row_start = (hcount == 11'd0) && !vcount[0];
    assign wr_slot   = !hcount[0] && !vcount[0];
    assign iss_slot  = hcount[0] && !vcount[0];

    always_comb begin
        nxt   = cur;
        abort = 1'b0;
        case (cur)
            IDLE:  if (sof && enable) nxt = PRIME;
            PRIME: begin
                if (sof) begin
                    nxt   = enable ? PRIME : IDLE;
                    abort = 1'b1;
                end else if (row_start && row == 10'd1) begin
                    nxt = RUN;
                end
            end
            RUN: begin
                if (sof) begin
                    nxt   = enable ? PRIME : IDLE;
                    abort = 1'b1;
                end else if (row_start && row == H_C) begin
                    nxt = FLUSH;
                end
            end
            FLUSH: begin
                // Leaving the flush row either wraps straight into the next frame
                // or, if blanking lines follow, drops to IDLE.
                if (sof)              nxt = enable ? PRIME : IDLE;
                else if (row != H_C)  nxt = IDLE;
            end
            default: nxt = IDLE;
        endcase
    end

    // Slot decisions use the next state so the SOF cycle itself writes column 0.
    assign done    = (cur == FLUSH) && (nxt != FLUSH);
    assign wr_now  = wr_slot && (nxt == PRIME || nxt == RUN) && (col < W_C) && (row < H_C);
    assign rot_now = row_start && (row >= 10'd1) && (nxt != IDLE);
    assign iss_now = iss_slot && (nxt == RUN || nxt == FLUSH) && (col >= 10'd1) && (col <= W_C);

    // Taps row-major, bit 0 = top-left. Columns: bits {0,3,6} left, {2,5,8} right.
    always_comb begin
        mask_now = 9'h1FF;
        if (col < 10'd2) mask_now = mask_now & ~9'b001_001_001;
        if (col == W_C)  mask_now = mask_now & ~9'b100_100_100;
        if (row < 10'd2) mask_now = mask_now & ~9'b000_000_111;
        if (row == H_C)  mask_now = mask_now & ~9'b111_000_000;
    end

    logic               wr_s1;
    logic [8:0]         addr_s1;
    logic               issue_r;
    logic [8:0]         cx_r, cy_r;
    logic [LATENCY-1:0] pv;
    logic [8:0]         px [LATENCY];
    logic [8:0]         py [LATENCY];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur        <= IDLE;
            frame_done <= 1'b0;
            rotate     <= 1'b0;
            wr_s1      <= 1'b0;
            addr_s1    <= '0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            rd_col     <= '0;
            win_mask   <= '0;
            cx_r       <= '0;
            cy_r       <= '0;
            issue_r    <= 1'b0;
            pv         <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                px[i] <= '0;
                py[i] <= '0;
            end
        end else begin
            cur        <= nxt;
            frame_done <= done;
            rotate     <= rot_now;
            // The write trails rotate by a cycle so the buffer shift settles
            // before column 0 of the new row lands in line_buffer_2.
            wr_s1      <= wr_now;
            addr_s1    <= col[8:0];
            wr_en      <= wr_s1;
            wr_addr    <= addr_s1;
            issue_r    <= iss_now;
            if (iss_now) begin
                rd_col   <= col[8:0];
                win_mask <= mask_now;
                cx_r     <= col[8:0] - 9'd1;
                cy_r     <= row[8:0] - 9'd1;
            end
            // Coordinates only advance behind a valid, so the last stage holds
            // the most recent result between issues.
            pv[0] <= issue_r;
            if (issue_r) begin
                px[0] <= cx_r;
                py[0] <= cy_r;
            end
            for (int i = 1; i < LATENCY; i++) begin
                pv[i] <= pv[i-1];
                if (pv[i-1]) begin
                    px[i] <= px[i-1];
                    py[i] <= py[i-1];
                end
            end
        end
    end

    assign out_valid = pv[LATENCY-1];
    assign out_x     = px[LATENCY-1];
    assign out_y     = py[LATENCY-1];
    assign busy      = (cur != IDLE);
    assign state     = cur;

`ifdef MEDIAN_CTRL_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_cnt <= '0;
            abort_cnt <= '0;
        end else begin
            if (done && frame_cnt != 16'hFFFF) frame_cnt <= frame_cnt + 16'd1;
            if (abort && abort_cnt != 8'hFF)   abort_cnt <= abort_cnt + 8'd1;
        end
    end
`endif

endmodule
